// File: rtl/rvlab_jtag_seq.sv
// JTAG master sequencer: turns RESET/IRSCAN/DRSCAN/IDLE commands into TCK/TMS/TDI slot
// sequences that start and end in Run-Test/Idle, and returns the TDO bits captured while shifting.
module rvlab_jtag_seq #(
    parameter int unsigned ClkDiv = 4,
    parameter int unsigned MaxLen = 64,
    localparam int unsigned LenW = $clog2(MaxLen + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LenW-1:0]   cmd_len_i,
    input  logic [MaxLen-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    output logic              trst_no,
    input  logic              tdo_i
);
    localparam int unsigned CntW = LenW + 1;
    localparam int unsigned PhW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [1:0] OpReset = 2'd0;
    localparam logic [1:0] OpIr    = 2'd1;
    localparam logic [1:0] OpIdle  = 2'd3;

    typedef enum logic [2:0] {StAutoRst, StIdle, StPre, StShift, StPost, StRsp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PhW-1:0]    ph_q, ph_d;
    logic              hi_q, hi_d, run_q, run_d, load;
    logic [1:0]        op_q, op_d;
    logic [LenW-1:0]   len_q, len_d, len_eff;
    logic [MaxLen-1:0] data_q, data_d, cap_q, cap_d;
    logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;

    function automatic logic [CntW-1:0] slot_count(state_e st, logic [1:0] op,
                                                   logic [LenW-1:0] len);
        logic [CntW-1:0] n;
        n = '0;
        case (st)
            StAutoRst: n = CntW'(6);
            StPre:     n = (op == OpIr) ? CntW'(4) : CntW'(3);
            StShift:   n = CntW'(len);
            StPost:    n = (op == OpReset) ? CntW'(6) : (op == OpIdle) ? CntW'(len) : CntW'(2);
            default:   n = '0;
        endcase
        return n;
    endfunction

    function automatic logic slot_tms(state_e st, logic [CntW-1:0] cnt, logic [1:0] op,
                                      logic [LenW-1:0] len);
        logic t;
        t = 1'b0;
        case (st)
            StAutoRst: t = (cnt != CntW'(5));
            StPre:     t = (op == OpIr) ? (cnt < CntW'(2)) : (cnt == '0);
            StShift:   t = (cnt == CntW'(len) - CntW'(1));
            StPost:    t = (op == OpReset) ? (cnt != CntW'(5)) : (op == OpIdle) ? 1'b0
                                                                             : (cnt == '0);
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

    assign cmd_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StRsp);
    assign rsp_data_o  = cap_q;
    assign busy_o      = (state_q == StAutoRst) || (state_q == StPre) ||
                         (state_q == StShift) || (state_q == StPost);
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign trst_no     = ~rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        hi_d    = hi_q;
        run_d   = run_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        load    = 1'b0;

        if (cmd_len_i == '0) begin
            len_eff = LenW'(1);
        end else if (cmd_len_i > LenW'(MaxLen)) begin
            len_eff = LenW'(MaxLen);
        end else begin
            len_eff = cmd_len_i;
        end

        if (run_q) begin
            if (ph_q == PhW'(ClkDiv - 1)) begin
                ph_d  = '0;
                hi_d  = ~hi_q;
                tck_d = ~hi_q;
                if (!hi_q) begin
                    if (state_q == StShift) begin
                        for (int unsigned i = 0; i < MaxLen; i++) begin
                            if (cnt_q == CntW'(i)) cap_d[i] = tdo_i;
                        end
                    end
                end else begin
                    // Falling TCK ends the slot; the next slot's TMS/TDI launch here.
                    load = 1'b1;
                    if (cnt_q + CntW'(1) == slot_count(state_q, op_q, len_q)) begin
                        cnt_d = '0;
                        case (state_q)
                            StAutoRst: state_d = StIdle;
                            StPre:     state_d = StShift;
                            StShift:   state_d = StPost;
                            default:   state_d = StRsp;
                        endcase
                        run_d = (state_d != StIdle) && (state_d != StRsp);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end else begin
                ph_d = ph_q + PhW'(1);
            end
        end else begin
            case (state_q)
                StAutoRst: run_d = 1'b1;
                StIdle: begin
                    if (cmd_valid_i) begin
                        load   = 1'b1;
                        op_d   = cmd_op_i;
                        data_d = cmd_data_i;
                        cap_d  = '0;
                        len_d  = (cmd_op_i == OpIdle) ? cmd_len_i : len_eff;
                        cnt_d  = '0;
                        ph_d   = '0;
                        hi_d   = 1'b0;
                        run_d  = 1'b1;
                        if (cmd_op_i == OpReset) begin
                            state_d = StPost;
                        end else if (cmd_op_i == OpIdle) begin
                            state_d = (cmd_len_i == '0) ? StRsp : StPost;
                            run_d   = (cmd_len_i != '0);
                        end else begin
                            state_d = StPre;
                        end
                    end
                end
                StRsp: if (rsp_ready_i) state_d = StIdle;
                default: ;
            endcase
        end

        if (load) begin
            tms_d = run_d ? slot_tms(state_d, cnt_d, op_d, len_d) : 1'b0;
            tdi_d = 1'b0;
            if (state_d == StShift) begin
                for (int unsigned i = 0; i < MaxLen; i++) begin
                    if (cnt_d == CntW'(i)) tdi_d = data_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StAutoRst;
            cnt_q   <= '0;
            ph_q    <= '0;
            hi_q    <= 1'b0;
            run_q   <= 1'b0;
            op_q    <= 2'd0;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            hi_q    <= hi_d;
            run_q   <= run_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end
endmodule

// File: tb/tb_rvlab_jtag_seq.sv
// Bench for rvlab_jtag_seq: drives commands into a sequencer wired to a behavioural debug TAP,
// scoreboards responses and latencies, and checks a ClkDiv=1 instance's RESET waveform.
module tb_rvlab_jtag_seq;
    localparam int unsigned CD = 4;
    localparam int unsigned ML = 64;
    localparam int unsigned LW = $clog2(ML + 1);
    localparam logic [31:0] IdcodeValue = 32'h2000_1DB3;
    localparam logic [31:0] DtmcsValue  = 32'h0000_1071;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1, busy;
    logic [1:0] cmd_op = 2'd0;
    logic [LW-1:0] cmd_len = '0;
    logic [ML-1:0] cmd_data = '0, rsp_data;
    logic tck, tms, tdi, trst_n, tdo = 1'b0;
    logic cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, busy1, tck1, tms1, tdi1, trst_n1;
    logic [1:0] cmd_op1 = 2'd0;
    logic [ML-1:0] rsp_data1;
    logic tdo1 = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic tms_log[$];
    logic tms_log1[$];

    always #5 clk = ~clk;

    rvlab_jtag_seq #(.ClkDiv(CD), .MaxLen(ML)) u_dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .busy_o(busy), .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .trst_no(trst_n), .tdo_i(tdo)
    );

    rvlab_jtag_seq #(.ClkDiv(1), .MaxLen(ML)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid1), .cmd_ready_o(cmd_ready1),
        .cmd_op_i(cmd_op1), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data1),
        .busy_o(busy1), .tck_o(tck1), .tms_o(tms1), .tdi_o(tdi1), .trst_no(trst_n1), .tdo_i(tdo1)
    );

    // Behavioural TAP: 5-bit IR (capture 0x05), IDCODE at IR=0x01, DTMCS at IR=0x10, else bypass.
    typedef enum logic [3:0] {Tlr, Rti, SelDr, CapDr, ShDr, Ex1Dr, PauDr, Ex2Dr, UpdDr,
                              SelIr, CapIr, ShIr, Ex1Ir, PauIr, Ex2Ir, UpdIr} tap_e;
    tap_e tap_st = Tlr;
    logic [4:0] ir = 5'h01, irs = 5'h00;
    logic [31:0] dr = 32'h0;

    function automatic tap_e tap_next(tap_e s, logic m);
        case (s)
            Tlr:   return m ? Tlr : Rti;
            Rti:   return m ? SelDr : Rti;
            SelDr: return m ? SelIr : CapDr;
            CapDr: return m ? Ex1Dr : ShDr;
            ShDr:  return m ? Ex1Dr : ShDr;
            Ex1Dr: return m ? UpdDr : PauDr;
            PauDr: return m ? Ex2Dr : PauDr;
            Ex2Dr: return m ? UpdDr : ShDr;
            UpdDr: return m ? SelDr : Rti;
            SelIr: return m ? Tlr : CapIr;
            CapIr: return m ? Ex1Ir : ShIr;
            ShIr:  return m ? Ex1Ir : ShIr;
            Ex1Ir: return m ? UpdIr : PauIr;
            PauIr: return m ? Ex2Ir : PauIr;
            Ex2Ir: return m ? UpdIr : ShIr;
            default: return m ? SelDr : Rti;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st <= Tlr;
            ir     <= 5'h01;
        end else begin
            case (tap_st)
                Tlr:   ir <= 5'h01;
                CapDr: dr <= (ir == 5'h01) ? IdcodeValue : (ir == 5'h10) ? DtmcsValue : 32'h0;
                ShDr:  dr <= (ir == 5'h01 || ir == 5'h10) ? {tdi, dr[31:1]} : {31'h0, tdi};
                CapIr: irs <= 5'h05;
                ShIr:  irs <= {tdi, irs[4:1]};
                UpdIr: ir <= irs;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck) tdo <= (tap_st == ShDr) ? dr[0] : (tap_st == ShIr) ? irs[0] : 1'b0;
    always @(posedge tck) tms_log.push_back(tms);
    always @(posedge tck1) tms_log1.push_back(tms1);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, input logic [63:0] data,
                         output int waits);
        waits     = 0;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Cycle (accept = 0) at which rsp_valid is first seen.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!rsp_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_ready(output int n, output logic saw_rsp);
        n = 0;
        saw_rsp = 1'b0;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            saw_rsp |= rsp_valid;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [LW-1:0] len,
                           input logic [63:0] data, input logic [63:0] exp, input int slots);
        int w, c;
        exp_q.push_back(exp);
        issue(op, len, data, w);
        wait_rsp(c);
        check({tag, "_lat"}, 64'(c), 64'(1 + 2 * CD * slots));
        check(tag, rsp_data, exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, c;
        logic bad;
        logic [63:0] held, v;

        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck), 64'h0);
        check("rst_tms", 64'(tms), 64'h1);
        check("rst_tdi", 64'(tdi), 64'h0);
        check("rst_trst", 64'(trst_n), 64'h0);
        check("rst_ready", 64'(cmd_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_busy", 64'(busy), 64'h1);

        rst = 1'b0;
        wait_ready(n, bad);
        check("release_lat", 64'(n), 64'(1 + 12 * CD));
        check("idle_busy", 64'(busy), 64'h0);
        check("trst_released", 64'(trst_n), 64'h1);

        run_cmd("dr_idcode", 2'd2, LW'(32), 64'h0, {32'h0, IdcodeValue}, 37);
        run_cmd("dr_len0", 2'd2, LW'(0), 64'h0, 64'h1, 6);
        run_cmd("dr_clamp", 2'd2, LW'(100), {32'hFFFF_FFFF, 32'hA5C3_0F96},
                {32'hA5C3_0F96, IdcodeValue}, 69);
        run_cmd("ir_dtmcs", 2'd1, LW'(5), 64'h10, 64'h05, 11);
        run_cmd("dr_dtmcs", 2'd2, LW'(32), 64'h0, {32'h0, DtmcsValue}, 37);

        tms_log.delete();
        run_cmd("idle0", 2'd3, LW'(0), 64'h0, 64'h0, 0);
        check("idle0_tck", 64'(tms_log.size()), 64'h0);

        // IDLE 3, then hold the response while the next command waits.
        tms_log.delete();
        exp_q.push_back(64'h0);
        issue(2'd3, LW'(3), 64'h0, n);
        rsp_ready = 1'b0;
        wait_rsp(c);
        check("idle3_lat", 64'(c), 64'(1 + 2 * CD * 3));
        check("idle3_tck", 64'(tms_log.size()), 64'h3);
        bad = 1'b0;
        foreach (tms_log[i]) bad |= tms_log[i];
        check("idle3_tms", 64'(bad), 64'h0);
        held = rsp_data;
        cmd_op = 2'd3;
        cmd_len = '0;
        cmd_valid = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready || !rsp_valid || rsp_data !== held) bad = 1'b1;
        end
        check("hold_stable", 64'(bad), 64'h0);
        check("hold_data", held, exp_q.pop_front());
        rsp_ready = 1'b1;
        @(negedge clk);
        check("ready_after_hs", 64'(cmd_ready), 64'h1);
        issue(2'd3, LW'(0), 64'h0, n);
        check("accept_waits", 64'(n), 64'h0);
        wait_rsp(c);
        check("idle0b_lat", 64'(c), 64'h1);

        // Reset in the 10th shift slot of a 32-bit DR scan.
        issue(2'd2, LW'(32), 64'h0, n);
        repeat (2 * CD * 12 + CD) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        check("abort_tck", 64'(tck), 64'h0);
        check("abort_trst", 64'(trst_n), 64'h0);
        check("abort_tms", 64'(tms), 64'h1);
        check("abort_rsp_valid", 64'(rsp_valid), 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ready(n, bad);
        check("abort_release_lat", 64'(n), 64'(1 + 12 * CD));
        check("abort_no_rsp", 64'(bad), 64'h0);
        run_cmd("dr_idcode2", 2'd2, LW'(32), 64'h0, {32'h0, IdcodeValue}, 37);

        // ClkDiv=1 instance: RESET command waveform.
        tms_log1.delete();
        cmd_op1 = 2'd0;
        cmd_valid1 = 1'b1;
        n = 0;
        while (!cmd_ready1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        c = 1;
        @(negedge clk);
        while (!rsp_valid1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("reset1_lat", 64'(c), 64'd13);
        check("reset1_data", rsp_data1, 64'h0);
        repeat (10) @(negedge clk);
        check("reset1_tck", 64'(tms_log1.size()), 64'h6);
        v = 64'h0;
        foreach (tms_log1[i]) v = {v[62:0], tms_log1[i]};
        check("reset1_tms", v, 64'b111110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rvlab_jtag_seq.md
# rvlab_jtag_seq

JTAG master sequencer: accepts high-level scan commands (TAP reset, IR scan, DR scan, idle clocks) over a valid/ready interface. It generates TCK/TMS/TDI for a downstream debug TAP and returns the TDO bits captured during each scan. It sits between an on-chip or bench-side command source and the `rvlab_tap` JTAG pins, so the DTM can be driven without an external probe.

## Interface
- `ClkDiv`, default 4: `clk_i` cycles per TCK half-period; must be ≥1.
- `MaxLen`, default 64: maximum scan length in bits; `LenW = $clog2(MaxLen+1)`.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when both valid and ready are high.
- `cmd_op_i`  in  2  0=RESET, 1=IRSCAN, 2=DRSCAN, 3=IDLE.
- `cmd_len_i`  in  LenW  scan bits (IR/DR) or TCK count (IDLE); ignored for RESET.
- `cmd_data_i`  in  MaxLen  TDI bits, LSB shifted first.
- `rsp_valid_o`  out  1  response valid, held until accepted.
- `rsp_ready_i`  in  1  response accept.
- `rsp_data_o`  out  MaxLen  captured TDO bits, bit i = i-th shifted bit; unused bits 0.
- `busy_o`  out  1  sequence in progress, including the post-reset auto-reset.
- `tck_o`, `tms_o`, `tdi_o`  out  1  JTAG pins.
- `trst_no`  out  1  TAP reset: 0 while `rst_i` is high, else 1.
- `tdo_i`  in  1  JTAG TDO; synchronised externally.

## Operation
- The TAP's position is tracked implicitly. Every sequence starts and ends in Run-Test/Idle (RTI).
- Time unit is the slot: one TCK period of 2·ClkDiv `clk_i` cycles. Each slot has a low phase followed by a high phase.
- TMS per slot, where N is the effective length:
  - RESET: 1,1,1,1,1,0 (6 slots).
  - IRSCAN: 1,1,0,0, then N shift slots (TMS=0 except the last, which is 1), then 1,0 (N+6 slots).
  - DRSCAN: 1,0,0, then N shift slots as for IRSCAN, then 1,0 (N+5 slots).
  - IDLE: N slots of TMS=0. N=0 produces no slots.
- Length rules for IR/DR:
  - len=0 is treated as 1.
  - len>MaxLen is clamped to MaxLen.
  - For IDLE, len is used unclamped.
- TDI and TDO during scans:
  - In shift slot i, `tdi_o` = `cmd_data_i[i]`, latched at accept.
  - `tdo_i` sampled in shift slot i is written to response bit i.
  - In all other slots `tdi_o` = 0.
- Every accepted command produces exactly one response. RESET and IDLE return `rsp_data_o` = 0.
- Handshake:
  - `cmd_ready_o` = 1 only in IDLE state with no pending response.
  - After `rsp_valid_o` rises, no new command is accepted until the response handshake completes.
  - `rsp_valid_o` and `rsp_data_o` are stable while `rsp_ready_i` is low.
- FSM states:
  - AUTORST: entered on reset release; runs the RESET pattern with no response.
  - IDLE.
  - PRE: header TMS bits.
  - SHIFT.
  - POST: exit and update bits; for IDLE commands, the idle slots.
  - RSP.
  - Transitions:
    - AUTORST→IDLE.
    - IDLE→PRE on accept (RESET and IDLE ops go directly to POST).
    - PRE→SHIFT→POST→RSP.
    - RSP→IDLE on `rsp_ready_i`.
- Counters:
  - Phase counter 0..ClkDiv-1.
  - Slot-bit counter of LenW+1 bits; wraps only at slot boundaries.
- Reset values: `tck_o`=0, `tms_o`=1, `tdi_o`=0, `trst_no`=0, `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `busy_o`=1, state AUTORST.
- `rst_i` asserted mid-sequence: immediate abort and all outputs return to their reset values. No response is issued for the aborted command. The auto-reset reruns after release.

## Timing
- The accept cycle is cycle 0. Slot k's low phase starts at cycle 1+2·ClkDiv·k.
- `tms_o` and `tdi_o` change only on the cycle `tck_o` falls (slot start). They are stable for the whole slot.
- `tck_o` rises ClkDiv cycles into the slot.
- `tdo_i` is registered on the `clk_i` edge on which `tck_o` goes 1. The TAP drives TDO from TCK falling, so it is stable there.
- `rsp_valid_o` rises at cycle 1+2·ClkDiv·S, where S is the slot count. An IDLE command with N=0 gives `rsp_valid_o` at cycle 1.
- `tck_o` stays 0 whenever no slot is active.
- `busy_o` = 1 in AUTORST, PRE, SHIFT and POST.
- After `rst_i` falls, `cmd_ready_o` rises 1+12·ClkDiv cycles later.

## Test plan
- Reset release, then DRSCAN len=32, data=0, against `rvlab_tap` → `rsp_data_o[31:0]` = the TAP's IdcodeValue, `rsp_valid_o` at cycle 1+74·ClkDiv.
- IRSCAN len=5, data=0x10 → `rsp_data_o`=0x05 (capture pattern). A following DRSCAN len=32 → `rsp_data_o`=0x00001071 (DTMCS: version 1, abits 7, idle 1).
- ClkDiv=1: RESET command → `tms_o`=1 for exactly 5 TCK periods then 0 for 1. `rsp_data_o`=0. No TCK pulses outside those slots.
- IDLE len=0 → response at cycle 1 with no TCK edge. IDLE len=3 → exactly 3 TCK pulses with TMS=0.
- Hold `rsp_ready_i`=0 for 20 cycles with `cmd_valid_i`=1 → `cmd_ready_o` stays 0, response stable. Release → next command accepted the cycle after the response handshake.
- Assert `rst_i` at the 10th shift slot of a 32-bit DRSCAN → `tck_o`=0, `trst_no`=0, no response. After release, the auto-reset runs and a new IDCODE scan returns IdcodeValue.
